sc1_boot_sequencer: RTL
=======================

// Module: sc1_boot_sequencer
// PURPOSE
//  Sequences SoC start-up: holds the CPU in reset through a power-on delay, then opens a UART
//  boot window in which a host may stream a program into instruction memory. The block sits
//  between the UART byte interface, the imem write port and the CPU reset input of sc1_soc.
//  It releases the CPU when the window times out or a load completes.
// PARAMETERS
//  WIDTH_D         32          imem word width; fixed at 32 (4 bytes, little-endian)
//  DEPTH_I         10          imem address width; capacity 2**DEPTH_I words
//  RESET_TIMER_BIT 24          power-on delay ends when counter bit [RESET_TIMER_BIT] sets
//  LISTEN_CYCLES   12000000    boot-window length in clk cycles (1 s at 12 MHz)
//  BYTE_TIMEOUT    120000      max idle cycles between bytes inside a load
// PORTS
//  clk        in   1        system clock
//  reset_n    in   1        asynchronous, active-low reset
//  rx_data    in   8        received UART byte
//  rx_valid   in   1        1-cycle strobe; rx_data valid
//  tx_data    out  8        byte to transmit
//  tx_valid   out  1        transmit request; held until accepted
//  tx_ready   in   1        transmitter accepts tx_data when tx_valid&tx_ready at clk edge
//  imem_we    out  1        imem write strobe, 1 cycle
//  imem_addr  out  DEPTH_I  imem write word address
//  imem_wdata out  WIDTH_D  imem write data
//  cpu_reset  out  1        active-high reset to sc1_soc
//  booting    out  1        high in every state except RUN
// BEHAVIOUR
//  Reset (reset_n=0, async): state POR; cpu_reset=1, booting=1, imem_we=0, imem_addr=0,
//   imem_wdata=0, tx_valid=0, tx_data=0, all counters 0. All outputs registered.
//  POR:    counter increments each cycle; when bit RESET_TIMER_BIT is 1 -> LISTEN (timer cleared).
//  LISTEN: timer counts; rx_valid with rx_data=0x55 -> LEN0; other bytes ignored (timer keeps
//          running); timer reaching LISTEN_CYCLES-1 -> RUN.
//  LEN0/LEN1: capture word count N, low byte then high byte (16 bit). After LEN1:
//          N==0 -> ACK; N>2**DEPTH_I -> NAK; else -> DATA, word index=0, byte index=0.
//  DATA:   bytes shift into imem_wdata little-endian (byte0 -> [7:0]). On the cycle after the
//          4th byte's rx_valid: imem_we=1 for exactly 1 cycle, imem_addr=word index.
//          After word N-1 written -> ACK. Address never wraps (N bounded above).
//  ACK/NAK: tx_data=0x06 (ACK) / 0x15 (NAK), tx_valid=1 until tx_ready sampled high;
//          then ACK -> RUN, NAK -> LISTEN with timer restarted. rx bytes ignored here.
//  RUN:    cpu_reset=0 and booting=0 from the first cycle in RUN; terminal until reset_n.
//  Byte timeout: in LEN0/LEN1/DATA an idle counter resets on every rx_valid; reaching
//   BYTE_TIMEOUT -> NAK. Words already written stay in imem; partial word discarded.
//  rx_valid coincident with timeout: byte wins, counter cleared, no NAK.
//  rx_valid coincident with LISTEN expiry on 0x55: sync wins -> LEN0.
//  cpu_reset is 1 in every state except RUN; reset_n mid-load returns to POR, CPU held.
// TESTING  (bench params: RESET_TIMER_BIT=4, LISTEN_CYCLES=100, BYTE_TIMEOUT=20)
//  1. No host traffic -> cpu_reset falls ~100 cycles after POR ends; no imem_we, no tx.
//  2. 0x55,0x02,0x00, bytes 78 56 34 12 EF BE AD DE -> writes addr0=0x12345678,
//     addr1=0xDEADBEEF, each imem_we 1 cycle; tx 0x06; then cpu_reset=0.
//  3. 0x55,0x01,0x04 (N=1025 > 1024) -> tx 0x15, no imem_we, back in LISTEN, cpu_reset=1.
//  4. 0x55,0x01,0x00,0xAA then 25 idle cycles -> 0x15 at idle 20, no write, LISTEN re-entered.
//  5. tx_ready low 10 cycles during ACK -> tx_valid/tx_data=0x06 stable until accepted; RUN next.
//  6. reset_n pulsed low mid-DATA -> outputs at reset values immediately; POR sequence restarts.

Source files
------------

// File: rtl/sc1_boot_sequencer.sv
// sc1_boot_sequencer
//   Start-up sequencer for sc1_soc. Holds the CPU in reset through a power-on
//   delay, then opens a UART boot window in which a host may stream a program
//   into instruction memory. The CPU is released when the window times out or
//   a load completes with ACK.
//
//   Host protocol: 0x55 sync, word count N (16 bit, low byte first), then
//   N little-endian 32-bit words. The reply is 0x06 (ACK) or 0x15 (NAK).
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   rx_data     received UART byte
//   rx_valid    1-cycle strobe, rx_data valid
//   tx_data     byte to transmit
//   tx_valid    transmit request, held until tx_ready
//   tx_ready    transmitter accepts tx_data on tx_valid & tx_ready
//   imem_we     imem write strobe, 1 cycle per word
//   imem_addr   imem write word address
//   imem_wdata  imem write data
//   cpu_reset   active-high CPU reset, low only in RUN
//   booting     high in every state except RUN
//
// States
//   state  | meaning
//   POR    | power-on delay, counter runs until bit RESET_TIMER_BIT sets
//   LISTEN | boot window open, waiting for 0x55 sync
//   LEN0   | waiting for word count low byte
//   LEN1   | waiting for word count high byte
//   DATA   | receiving program words
//   ACK    | sending 0x06, then release CPU
//   NAK    | sending 0x15, then reopen boot window
//   RUN    | CPU running, terminal until reset
module sc1_boot_sequencer #(
  parameter int WIDTH_D         = 32,
  parameter int DEPTH_I         = 10,
  parameter int RESET_TIMER_BIT = 24,
  parameter int LISTEN_CYCLES   = 12000000,
  parameter int BYTE_TIMEOUT    = 120000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               imem_we,
  output logic [DEPTH_I-1:0] imem_addr,
  output logic [WIDTH_D-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               booting
);

  localparam int LW = (LISTEN_CYCLES > 1) ? $clog2(LISTEN_CYCLES) : 1;
  localparam int IW = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [LW-1:0] LISTEN_LAST = LW'(LISTEN_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(BYTE_TIMEOUT - 1);
  localparam logic [16:0]   CAPACITY    = 17'(2 ** DEPTH_I);

  typedef enum logic [2:0] {
    ST_POR, ST_LISTEN, ST_LEN0, ST_LEN1, ST_DATA, ST_ACK, ST_NAK, ST_RUN
  } state_t;

  state_t state, state_nxt;

  logic [RESET_TIMER_BIT:0] por_cnt;
  logic [LW-1:0]            listen_cnt;
  logic [IW-1:0]            idle_cnt;
  logic [7:0]               len_lo;
  logic [15:0]              len_words;
  logic [DEPTH_I-1:0]       word_idx;
  logic [1:0]               byte_idx;

  logic [15:0] len_rx;
  logic        in_load;
  logic        idle_expire;
  logic        word_done;
  logic        last_word;

  logic       cpu_reset_d;
  logic       booting_d;
  logic       tx_valid_d;
  logic [7:0] tx_data_d;

  assign len_rx      = {rx_data, len_lo};
  assign in_load     = (state == ST_LEN0) || (state == ST_LEN1) || (state == ST_DATA);
  // A byte arriving on the expiry cycle keeps the load alive.
  assign idle_expire = in_load && !rx_valid && (idle_cnt == IDLE_LAST);
  assign word_done   = (state == ST_DATA) && rx_valid && (byte_idx == 2'd3);
  assign last_word   = (16'(word_idx) == (len_words - 16'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_POR;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_POR:    if (por_cnt[RESET_TIMER_BIT]) state_nxt = ST_LISTEN;
      ST_LISTEN: begin
        // Sync wins over a coincident window expiry.
        if (rx_valid && (rx_data == 8'h55))  state_nxt = ST_LEN0;
        else if (listen_cnt == LISTEN_LAST) state_nxt = ST_RUN;
      end
      ST_LEN0: begin
        if (rx_valid)         state_nxt = ST_LEN1;
        else if (idle_expire) state_nxt = ST_NAK;
      end
      ST_LEN1: begin
        if (rx_valid) begin
          if (len_rx == 16'd0)                 state_nxt = ST_ACK;
          else if ({1'b0, len_rx} > CAPACITY) state_nxt = ST_NAK;
          else                                 state_nxt = ST_DATA;
        end else if (idle_expire) begin
          state_nxt = ST_NAK;
        end
      end
      ST_DATA: begin
        if (word_done && last_word) state_nxt = ST_ACK;
        else if (idle_expire)       state_nxt = ST_NAK;
      end
      ST_ACK:  if (tx_ready) state_nxt = ST_RUN;
      ST_NAK:  if (tx_ready) state_nxt = ST_LISTEN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_POR;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    cpu_reset_d = (state_nxt != ST_RUN);
    booting_d   = (state_nxt != ST_RUN);
    tx_valid_d  = (state_nxt == ST_ACK) || (state_nxt == ST_NAK);
    tx_data_d   = 8'h00;
    if (state_nxt == ST_ACK)      tx_data_d = 8'h06;
    else if (state_nxt == ST_NAK) tx_data_d = 8'h15;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_reset  <= 1'b1;
      booting    <= 1'b1;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      por_cnt    <= '0;
      listen_cnt <= '0;
      idle_cnt   <= '0;
      len_lo     <= 8'h00;
      len_words  <= 16'h0000;
      word_idx   <= '0;
      byte_idx   <= 2'd0;
    end else begin
      cpu_reset <= cpu_reset_d;
      booting   <= booting_d;
      tx_valid  <= tx_valid_d;
      tx_data   <= tx_data_d;

      if (state == ST_POR) por_cnt <= por_cnt + 1'b1;

      // Cleared whenever the window is left so a NAK reopens a full window.
      if ((state == ST_LISTEN) && (state_nxt == ST_LISTEN)) listen_cnt <= listen_cnt + 1'b1;
      else                                                  listen_cnt <= '0;

      if (in_load && !rx_valid) idle_cnt <= idle_cnt + 1'b1;
      else                      idle_cnt <= '0;

      imem_we <= word_done;
      if (word_done) imem_addr <= word_idx;

      if ((state == ST_LEN0) && rx_valid) len_lo <= rx_data;

      if ((state == ST_LEN1) && rx_valid) begin
        len_words <= len_rx;
        word_idx  <= '0;
        byte_idx  <= 2'd0;
      end

      // A partial word left by a timeout is simply overwritten by the next load.
      if ((state == ST_DATA) && rx_valid) begin
        case (byte_idx)
          2'd0:    imem_wdata[7:0]   <= rx_data;
          2'd1:    imem_wdata[15:8]  <= rx_data;
          2'd2:    imem_wdata[23:16] <= rx_data;
          default: imem_wdata[31:24] <= rx_data;
        endcase
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) word_idx <= word_idx + 1'b1;
      end
    end
  end

endmodule
